map_port_arbiter: RTL and testbench

Shares the single read port of the world-map memory between the video path and the Rojobot map-sensor requester. It converts display-timing pixel coordinates into map-cell addresses, then delivers map value, pixel coordinates and out-of-map flag to map_colorizer, all aligned to the same cycle. Bot reads are served in cycles the video path does not need, with a bounded-wait guarantee. It sits between the DTG, the map memory, map_colorizer and the bot sensor interface.

---
 rtl/map_pkg.sv | 55 +++++
 rtl/map_window_decode.sv | 39 +++
 rtl/map_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_map_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared definitions for the world-map read path: map geometry, cell encodings,
// arbiter states and the pixel record carried alongside a video read.
package map_pkg;

    localparam int MAP_DIM  = 128;
    localparam int MAP_BITS = 7;
    localparam int PIX_W    = 12;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ROAD   = 2'b01,
        FLOWER = 2'b10
    } map_value_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_BOT_ISSUED = 2'b01,
        ST_BOT_RETURN = 2'b10
    } arb_state_e;

    // Pixel attributes that travel with a memory read so they emerge with its data.
    typedef struct packed {
        logic             video_on;
        logic [PIX_W-1:0] row;
        logic [PIX_W-1:0] col;
        logic             oom;
        logic             stolen;
    } pix_stage_t;

    localparam pix_stage_t PIX_STAGE_RST = '{
        video_on: 1'b0,
        row:      '0,
        col:      '0,
        oom:      1'b1,
        stolen:   1'b0
    };

    // Out-of-map pixels show EMPTY; a stolen pixel repeats the last video value.
    function automatic logic [1:0] pick_map_value(
        input pix_stage_t  stage,
        input logic [1:0]  rdata,
        input logic [1:0]  hold
    );
        logic [1:0] result;
        if (stage.oom) begin
            result = EMPTY;
        end else if (stage.stolen) begin
            result = hold;
        end else begin
            result = rdata;
        end
        return result;
    endfunction

endpackage

// File: rtl/map_window_decode.sv
// Combinational translation of display coordinates into a map-cell address,
// flagging pixels that fall outside the map window or outside active video.
module map_window_decode
    import map_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int CELL_SHIFT = 2,
    parameter int ROW_OFFSET = 128,
    parameter int COL_OFFSET = 256
) (
    input  logic                  video_on,
    input  logic [PIX_W-1:0]      pixel_row,
    input  logic [PIX_W-1:0]      pixel_column,
    output logic                  in_map,
    output logic [ADDR_WIDTH-1:0] video_addr
);

    logic [PIX_W-1:0] rel_r;
    logic [PIX_W-1:0] rel_c;
    logic [PIX_W-1:0] cell_r;
    logic [PIX_W-1:0] cell_c;
    logic             row_under;
    logic             col_under;

    always_comb begin
        row_under = (pixel_row < PIX_W'(ROW_OFFSET));
        col_under = (pixel_column < PIX_W'(COL_OFFSET));
        rel_r     = pixel_row - PIX_W'(ROW_OFFSET);
        rel_c     = pixel_column - PIX_W'(COL_OFFSET);
        cell_r    = rel_r >> CELL_SHIFT;
        cell_c    = rel_c >> CELL_SHIFT;

        in_map = video_on && !row_under && !col_under &&
                 (cell_r < PIX_W'(MAP_DIM)) && (cell_c < PIX_W'(MAP_DIM));

        video_addr = ADDR_WIDTH'({cell_r[MAP_BITS-1:0], cell_c[MAP_BITS-1:0]});
    end

endmodule

// File: rtl/map_port_arbiter.sv
// Shares the map memory read port between the video pipeline and the bot sensor,
// with a starvation bound that lets the bot steal one video pixel when needed.
module map_port_arbiter
    import map_pkg::*;
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int CELL_SHIFT   = 2,
    parameter int ROW_OFFSET   = 128,
    parameter int COL_OFFSET   = 256,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  video_on,
    input  logic [11:0]           pixel_row,
    input  logic [11:0]           pixel_column,
    input  logic                  bot_req,
    input  logic [ADDR_WIDTH-1:0] bot_addr,
    output logic                  bot_ack,
    output logic [1:0]            bot_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [1:0]            mem_rdata,
    output logic [1:0]            map_value,
    output logic [11:0]           pix_row_o,
    output logic [11:0]           pix_col_o,
    output logic                  out_of_map,
    output logic                  video_on_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic                  in_map;
    logic [ADDR_WIDTH-1:0] video_addr;
    logic                  video_grant;
    logic                  bot_grant;

    arb_state_e            state_q,      state_d;
    logic [CNT_W-1:0]      starve_q,     starve_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic                  bot_ack_q,    bot_ack_d;
    logic [1:0]            bot_data_q,   bot_data_d;
    pix_stage_t            s1_q,         s1_d;
    pix_stage_t            s2_q,         s2_d;
    logic [1:0]            hold_q,       hold_d;
    logic [1:0]            map_value_q,  map_value_d;
    logic [11:0]           pix_row_q,    pix_row_d;
    logic [11:0]           pix_col_q,    pix_col_d;
    logic                  oom_q,        oom_d;
    logic                  vid_on_q,     vid_on_d;

    map_window_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CELL_SHIFT (CELL_SHIFT),
        .ROW_OFFSET (ROW_OFFSET),
        .COL_OFFSET (COL_OFFSET)
    ) u_decode (
        .video_on     (video_on),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .in_map       (in_map),
        .video_addr   (video_addr)
    );

    always_comb begin
        video_grant = in_map && (starve_q < CNT_W'(STARVE_LIMIT));
        bot_grant   = !video_grant && bot_req && (state_q == ST_IDLE);
    end

    // Stage 1: grant decision, address register and starve bookkeeping.
    always_comb begin
        mem_addr_d = mem_addr_q;
        if (video_grant) begin
            mem_addr_d = video_addr;
        end else if (bot_grant) begin
            mem_addr_d = bot_addr;
        end

        starve_d = starve_q;
        if (bot_grant || !bot_req) begin
            starve_d = '0;
        end else if (starve_q < CNT_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + CNT_W'(1);
        end

        s1_d.video_on = video_on;
        s1_d.row      = pixel_row;
        s1_d.col      = pixel_column;
        s1_d.oom      = !in_map;
        s1_d.stolen   = in_map && !video_grant;

        s2_d = s1_q;
    end

    always_comb begin
        state_d    = state_q;
        bot_ack_d  = 1'b0;
        bot_data_d = bot_data_q;
        case (state_q)
            ST_IDLE: begin
                if (bot_grant) begin
                    state_d = ST_BOT_ISSUED;
                end
            end
            ST_BOT_ISSUED: begin
                state_d = ST_BOT_RETURN;
            end
            ST_BOT_RETURN: begin
                state_d    = ST_IDLE;
                bot_ack_d  = 1'b1;
                bot_data_d = mem_rdata;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stage 3: memory data meets its pixel record.
    always_comb begin
        map_value_d = pick_map_value(s2_q, mem_rdata, hold_q);
        hold_d      = (!s2_q.oom && !s2_q.stolen) ? mem_rdata : hold_q;
        pix_row_d   = s2_q.row;
        pix_col_d   = s2_q.col;
        oom_d       = s2_q.oom;
        vid_on_d    = s2_q.video_on;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            mem_addr_q  <= '0;
            bot_ack_q   <= 1'b0;
            bot_data_q  <= 2'b00;
            s1_q        <= PIX_STAGE_RST;
            s2_q        <= PIX_STAGE_RST;
            hold_q      <= 2'b00;
            map_value_q <= 2'b00;
            pix_row_q   <= '0;
            pix_col_q   <= '0;
            oom_q       <= 1'b1;
            vid_on_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            bot_ack_q   <= bot_ack_d;
            bot_data_q  <= bot_data_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            hold_q      <= hold_d;
            map_value_q <= map_value_d;
            pix_row_q   <= pix_row_d;
            pix_col_q   <= pix_col_d;
            oom_q       <= oom_d;
            vid_on_q    <= vid_on_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign bot_ack    = bot_ack_q;
    assign bot_data   = bot_data_q;
    assign map_value  = map_value_q;
    assign pix_row_o  = pix_row_q;
    assign pix_col_o  = pix_col_q;
    assign out_of_map = oom_q;
    assign video_on_o = vid_on_q;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed bench for map_port_arbiter: vector table for the video pipeline plus
// hand-written bot, starvation, reset and row-walk sequences.
module tb_map_port_arbiter;

    logic        clk;
    logic        reset;
    logic        video_on;
    logic [11:0] pixel_row;
    logic [11:0] pixel_column;
    logic        bot_req;
    logic [13:0] bot_addr;
    logic        bot_ack;
    logic [1:0]  bot_data;
    logic [13:0] mem_addr;
    logic [1:0]  mem_rdata;
    logic [1:0]  map_value;
    logic [11:0] pix_row_o;
    logic [11:0] pix_col_o;
    logic        out_of_map;
    logic        video_on_o;

    int n_vec;
    int n_err;

    logic [1:0] mem [0:16383];

    map_port_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .video_on     (video_on),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .bot_req      (bot_req),
        .bot_addr     (bot_addr),
        .bot_ack      (bot_ack),
        .bot_data     (bot_data),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .map_value    (map_value),
        .pix_row_o    (pix_row_o),
        .pix_col_o    (pix_col_o),
        .out_of_map   (out_of_map),
        .video_on_o   (video_on_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        vo;
        logic [11:0] row;
        logic [11:0] col;
        logic        exp_oom;
        logic [13:0] exp_addr;
        logic [1:0]  exp_map;
    } vec_t;

    vec_t vecs [0:8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input logic vo, input logic [11:0] r, input logic [11:0] c);
        video_on     = vo;
        pixel_row    = r;
        pixel_column = c;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " map_value"},  32'(map_value),  32'h0);
        chk({tag, " pix_row_o"},  32'(pix_row_o),  32'h0);
        chk({tag, " pix_col_o"},  32'(pix_col_o),  32'h0);
        chk({tag, " out_of_map"}, 32'(out_of_map), 32'h1);
        chk({tag, " video_on_o"}, 32'(video_on_o), 32'h0);
        chk({tag, " bot_ack"},    32'(bot_ack),    32'h0);
        chk({tag, " bot_data"},   32'(bot_data),   32'h0);
        chk({tag, " mem_addr"},   32'(mem_addr),   32'h0);
    endtask

    initial begin
        logic [13:0] a;
        logic [1:0]  exp_map;
        n_vec = 0;
        n_err = 0;

        // Memory contents: value(a) = a[1:0] + a[7:6] + 1 (mod 4), cell 0x1234 = FLOWER.
        for (int i = 0; i < 16384; i++) begin
            a = 14'(i);
            mem[i] = 2'(a[1:0] + a[7:6] + 2'd1);
        end
        mem[14'h1234] = 2'b10;

        //            vo    row      col      oom   addr      map
        vecs[0] = '{1'b1, 12'd128, 12'd256, 1'b0, 14'h0000, 2'b01};
        vecs[1] = '{1'b1, 12'd100, 12'd300, 1'b1, 14'h0000, 2'b00};
        vecs[2] = '{1'b1, 12'd151, 12'd296, 1'b0, 14'h028A, 2'b01};
        vecs[3] = '{1'b1, 12'd639, 12'd767, 1'b0, 14'h3FFF, 2'b11};
        vecs[4] = '{1'b1, 12'd640, 12'd300, 1'b1, 14'h3FFF, 2'b00};
        vecs[5] = '{1'b1, 12'd200, 12'd768, 1'b1, 14'h3FFF, 2'b00};
        vecs[6] = '{1'b1, 12'd200, 12'd255, 1'b1, 14'h3FFF, 2'b00};
        vecs[7] = '{1'b0, 12'd200, 12'd300, 1'b1, 14'h3FFF, 2'b00};
        vecs[8] = '{1'b1, 12'd132, 12'd268, 1'b0, 14'h0083, 2'b10};

        // Reset with the DTG mid-frame.
        reset    = 1'b1;
        bot_req  = 1'b0;
        bot_addr = 14'h0;
        drive_pix(1'b1, 12'd300, 12'd400);
        tick();
        tick();
        chk_reset_outputs("reset_initial");

        // Run in-map video, then assert reset between edges: effect must be immediate.
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_pix(1'b1, 12'd140, 12'(300 + 4 * i));
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("reset_midframe");
        tick();
        reset = 1'b0;
        drive_pix(1'b0, 12'd0, 12'd0);
        tick();
        tick();
        tick();

        // Table-driven video vectors, each followed by blanking filler.
        for (int v = 0; v < 9; v++) begin
            drive_pix(vecs[v].vo, vecs[v].row, vecs[v].col);
            tick();
            chk($sformatf("vec%0d mem_addr", v), 32'(mem_addr), 32'(vecs[v].exp_addr));
            drive_pix(1'b0, 12'd0, 12'd0);
            tick();
            tick();
            chk($sformatf("vec%0d map_value", v),  32'(map_value),  32'(vecs[v].exp_map));
            chk($sformatf("vec%0d out_of_map", v), 32'(out_of_map), 32'(vecs[v].exp_oom));
            chk($sformatf("vec%0d pix_row_o", v),  32'(pix_row_o),  32'(vecs[v].row));
            chk($sformatf("vec%0d pix_col_o", v),  32'(pix_col_o),  32'(vecs[v].col));
            chk($sformatf("vec%0d video_on_o", v), 32'(video_on_o), 32'(vecs[v].vo));
            $display("vec %0d row=%0d col=%0d map=%0h oom=%0b addr=%0h",
                     v, vecs[v].row, vecs[v].col, map_value, out_of_map, mem_addr);
        end

        // Bot read during blanking.
        drive_pix(1'b0, 12'd0, 12'd0);
        bot_req  = 1'b1;
        bot_addr = 14'h1234;
        tick();
        chk("bot_blank grant mem_addr", 32'(mem_addr), 32'h1234);
        chk("bot_blank ack g", 32'(bot_ack), 32'h0);
        tick();
        chk("bot_blank ack g+1", 32'(bot_ack), 32'h0);
        tick();
        chk("bot_blank ack g+2", 32'(bot_ack), 32'h1);
        chk("bot_blank data", 32'(bot_data), 32'h2);
        bot_req = 1'b0;
        tick();
        chk("bot_blank ack single pulse", 32'(bot_ack), 32'h0);
        $display("bot read addr=1234 data=%0h", bot_data);
        // Immediate grant on a fresh request shows the arbiter is back in IDLE.
        bot_req  = 1'b1;
        bot_addr = 14'h0003;
        tick();
        chk("bot_again grant mem_addr", 32'(mem_addr), 32'h0003);
        tick();
        tick();
        chk("bot_again ack", 32'(bot_ack), 32'h1);
        chk("bot_again data", 32'(bot_data), 32'h0);
        bot_req = 1'b0;
        tick();
        $display("bot read addr=0003 data=%0h", bot_data);

        // Starvation: bot_req held across continuous in-map video on map row 0.
        bot_addr = 14'h1234;
        for (int t = 0; t < 73; t++) begin
            if (t < 70) drive_pix(1'b1, 12'd128, 12'(256 + 4 * t));
            else        drive_pix(1'b0, 12'd0, 12'd0);
            bot_req = (t <= 66);
            tick();
            if (t < 70) begin
                chk($sformatf("starve t%0d mem_addr", t), 32'(mem_addr),
                    (t == 64) ? 32'h1234 : 32'(t));
            end
            chk($sformatf("starve t%0d bot_ack", t), 32'(bot_ack), (t == 66) ? 32'h1 : 32'h0);
            if (t == 66) chk("starve bot_data", 32'(bot_data), 32'h2);
            if (t >= 60 && t <= 68) begin
                a       = 14'(t - 2);
                exp_map = (t - 2 == 64) ? mem[63] : mem[a];
                chk($sformatf("starve pix%0d map_value", t - 2), 32'(map_value), 32'(exp_map));
                chk($sformatf("starve pix%0d out_of_map", t - 2), 32'(out_of_map), 32'h0);
                chk($sformatf("starve pix%0d pix_col_o", t - 2), 32'(pix_col_o),
                    32'(256 + 4 * (t - 2)));
                $display("starve pix %0d map=%0h addr=%0h ack=%0b",
                         t - 2, map_value, mem_addr, bot_ack);
            end
        end

        // Reset while a bot read is in BOT_ISSUED.
        drive_pix(1'b0, 12'd0, 12'd0);
        bot_req  = 1'b1;
        bot_addr = 14'h0100;
        tick();
        chk("rst_issued grant mem_addr", 32'(mem_addr), 32'h0100);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_issued mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_issued out_of_map", 32'(out_of_map), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_issued no ack %0d", i), 32'(bot_ack), 32'h0);
        end
        reset = 1'b0;
        tick();
        chk("rst_retry grant mem_addr", 32'(mem_addr), 32'h0100);
        chk("rst_retry ack g", 32'(bot_ack), 32'h0);
        tick();
        chk("rst_retry ack g+1", 32'(bot_ack), 32'h0);
        tick();
        chk("rst_retry ack g+2", 32'(bot_ack), 32'h1);
        chk("rst_retry data", 32'(bot_data), 32'h1);
        bot_req = 1'b0;
        tick();
        $display("bot retry addr=0100 data=%0h", bot_data);

        // Walk every column of map row 0.
        for (int c = 256; c < 768; c++) begin
            drive_pix(1'b1, 12'd128, 12'(c));
            tick();
            chk($sformatf("walk col%0d mem_addr", c), 32'(mem_addr), 32'((c - 256) >> 2));
        end
        chk("walk last cell", 32'(mem_addr), 32'h007F);
        $display("walk row0 last addr=%0h", mem_addr);
        drive_pix(1'b0, 12'd0, 12'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
